alu_issue: RTL and testbench

- Initiator end of the combinational ALU interface (A, B, 3-bit ALUOp in; C out).
- Accepts operation requests over a valid/ready handshake and buffers them in an in-order FIFO.
- Drives the ALU from the FIFO head, captures the ALU result into an output register, and presents it over a valid/ready response handshake.
- Sits between a command source (test sequencer or control unit) and the ALU.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_issue_if.sv | 33 +++
 rtl/alu_req_fifo.sv | 59 +++++
 rtl/alu_issue.sv | 73 +++++++
 tb/tb_alu_issue.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes and request entry for the ALU issue block
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SRL = 3'd4;
    localparam logic [2:0] OP_SRA = 3'd5;
    localparam logic [2:0] OP_UGT = 3'd6;
    localparam logic [2:0] OP_SGT = 3'd7;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [2:0]        op;
    } alu_req_t;

    localparam int REQ_W = $bits(alu_req_t);

endpackage

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - request, ALU drive and response signals of the ALU issue block
interface alu_issue_if #(
    parameter int DATA_W = 32
);

    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [2:0]        req_op;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_c;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_c;
    logic [2:0]        rsp_op;
    logic              rsp_zero;

    modport master (
        input  req_valid, req_a, req_b, req_op, alu_c, rsp_ready,
        output req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_c, rsp_op, rsp_zero
    );

    modport slave (
        output req_valid, req_a, req_b, req_op, alu_c, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_c, rsp_op, rsp_zero
    );

endinterface

// File: rtl/alu_req_fifo.sv
// rtl/alu_req_fifo.sv - in-order request FIFO with registered occupancy count
module alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 67
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [W-1:0]           wdata_i,
    input  logic                   pop_i,
    output logic [W-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Guarded here so callers may hold push/pop high regardless of state.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - queues ALU requests, drives the ALU from the head, registers results
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    alu_issue_if.master bus
);

    alu_req_t                wr_entry;
    alu_req_t                head;
    logic [REQ_W-1:0]        head_bits;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    cap;

    logic                    rsp_valid_q;
    logic [DATA_W-1:0]       rsp_c_q;
    logic [2:0]              rsp_op_q;
    logic                    rsp_zero_q;

    assign wr_entry = '{a: bus.req_a, b: bus.req_b, op: bus.req_op};
    assign head     = alu_req_t'(head_bits);

    // Capture whenever the response register is free or being drained this edge.
    assign cap = !fifo_empty && (!rsp_valid_q || bus.rsp_ready);

    alu_req_fifo #(
        .DEPTH (DEPTH),
        .W     (REQ_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (bus.req_valid),
        .wdata_i (wr_entry),
        .pop_i   (cap),
        .rdata_o (head_bits),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.req_ready = !fifo_full;
    assign bus.alu_a     = fifo_empty ? '0 : head.a;
    assign bus.alu_b     = fifo_empty ? '0 : head.b;
    assign bus.alu_op    = fifo_empty ? 3'd0 : head.op;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_q <= 1'b0;
            rsp_c_q     <= '0;
            rsp_op_q    <= 3'd0;
            rsp_zero_q  <= 1'b0;
        end else if (cap) begin
            rsp_valid_q <= 1'b1;
            rsp_c_q     <= bus.alu_c;
            rsp_op_q    <= head.op;
            rsp_zero_q  <= (bus.alu_c == '0);
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_c     = rsp_c_q;
    assign bus.rsp_op    = rsp_op_q;
    assign bus.rsp_zero  = rsp_zero_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - randomized and directed bench for alu_issue with a scoreboard model
module tb_alu_issue;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_if #(.DATA_W(32)) bus ();

    alu_issue #(.DATA_W(32), .DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_SRL:  return a >> b[4:0];
            OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            OP_UGT:  return (a > b) ? 32'd1 : 32'd0;
            default: return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
        endcase
    endfunction

    assign bus.alu_c = alu_fn(bus.alu_a, bus.alu_b, bus.alu_op);

    typedef struct {
        logic [31:0] c;
        logic [2:0]  op;
    } exp_t;

    exp_t exp_q[$];
    int   rsp_cyc[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   idx;
    bit   acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every held or accepted response must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            if (bus.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("rsp_c", bus.rsp_c, exp_q[0].c);
                    chk("rsp_op", {29'd0, bus.rsp_op}, {29'd0, exp_q[0].op});
                    chk("rsp_zero", {31'd0, bus.rsp_zero}, {31'd0, exp_q[0].c == 32'd0});
                    if (bus.rsp_ready) begin
                        void'(exp_q.pop_front());
                        rsp_cyc.push_back(cyc);
                    end
                end
            end
            if (bus.req_valid && bus.req_ready)
                exp_q.push_back('{c: alu_fn(bus.req_a, bus.req_b, bus.req_op), op: bus.req_op});
        end
    end

    task automatic cycle(output bit accepted);
        @(negedge clk);
        accepted = bus.req_valid && bus.req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bus.req_a  = a;
        bus.req_b  = b;
        bus.req_op = op;
    endtask

    task automatic push_wait(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        int  budget = 0;
        bit  got = 0;
        set_req(a, b, op);
        bus.req_valid = 1'b1;
        while (!got && budget < 50) begin
            cycle(got);
            budget++;
        end
        bus.req_valid = 1'b0;
        if (!got) chk("push_timeout", 32'd1, 32'd0);
    endtask

    task automatic drain();
        int budget = 0;
        bit a;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b0;
        while ((bus.rsp_valid || exp_q.size() != 0) && budget < 100) begin
            cycle(a);
            budget++;
        end
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    task automatic bp_step();
        bit a;
        cycle(a);
        if (a) begin
            idx++;
            if (idx > 10) bus.req_valid = 1'b0;
            else set_req(idx, idx, OP_ADD);
        end
    endtask

    logic [31:0] s_a [4] = '{32'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] s_b [4] = '{32'd5, 32'd4, 32'd1, 32'd1};
    logic [2:0]  s_op[4] = '{OP_SUB, OP_SRA, OP_SGT, OP_UGT};

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n0;
        int budget;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        set_req(32'd0, 32'd0, 3'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_c", bus.rsp_c, 32'd0);
        chk("rst_rsp_op", {29'd0, bus.rsp_op}, 32'd0);
        chk("rst_rsp_zero", {31'd0, bus.rsp_zero}, 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single op latency
        bus.rsp_ready = 1'b1;
        set_req(32'd5, 32'd3, OP_ADD);
        bus.req_valid = 1'b1;
        cycle(acc);
        bus.req_valid = 1'b0;
        chk("single_acc", {31'd0, acc}, 32'd1);
        chk("single_not_yet", {31'd0, bus.rsp_valid}, 32'd0);
        chk("single_alu_a", bus.alu_a, 32'd5);
        cycle(acc);
        chk("single_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("single_c", bus.rsp_c, 32'd8);
        chk("single_op", {29'd0, bus.rsp_op}, 32'd0);
        chk("single_zero", {31'd0, bus.rsp_zero}, 32'd0);
        cycle(acc);
        chk("single_done", {31'd0, bus.rsp_valid}, 32'd0);

        // Back-to-back stream
        n0 = rsp_cyc.size();
        bus.req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(s_a[i], s_b[i], s_op[i]);
            cycle(acc);
            chk("stream_acc", {31'd0, acc}, 32'd1);
        end
        bus.req_valid = 1'b0;
        repeat (4) cycle(acc);
        chk("stream_count", rsp_cyc.size() - n0, 32'd4);
        if (rsp_cyc.size() - n0 == 4)
            chk("stream_spacing", rsp_cyc[n0 + 3] - rsp_cyc[n0], 32'd3);

        // Zero flag
        push_wait(32'hF0F0_F0F0, 32'h0F0F_0F0F, OP_AND);
        cycle(acc);
        chk("zero_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("zero_c", bus.rsp_c, 32'd0);
        chk("zero_flag", {31'd0, bus.rsp_zero}, 32'd1);
        drain();

        // Backpressure, then a single-cycle release at full
        bus.rsp_ready = 1'b0;
        idx = 1;
        set_req(32'd1, 32'd1, OP_ADD);
        bus.req_valid = 1'b1;
        repeat (12) bp_step();
        chk("bp_accepted", idx - 1, 32'd5);
        chk("bp_ready_low", {31'd0, bus.req_ready}, 32'd0);
        bus.rsp_ready = 1'b1;
        bp_step();
        chk("full_pop_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("full_pop_noacc", idx - 1, 32'd5);
        bus.rsp_ready = 1'b0;
        bp_step();
        chk("full_refill_acc", idx - 1, 32'd6);
        chk("full_refill_ready", {31'd0, bus.req_ready}, 32'd0);
        bus.rsp_ready = 1'b1;
        budget = 0;
        while (idx <= 10 && budget < 40) begin
            bp_step();
            budget++;
        end
        chk("bp_all_accepted", idx - 1, 32'd10);
        drain();

        // Randomized traffic
        bus.req_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!bus.req_valid || acc) begin
                set_req(rnd_operand(), rnd_operand(), 3'($urandom_range(0, 7)));
                bus.req_valid = ($urandom_range(0, 3) != 0);
            end
            bus.rsp_ready = ($urandom_range(0, 2) != 0);
            cycle(acc);
        end
        drain();

        // Reset mid-operation
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        n0 = 0;
        budget = 0;
        while (n0 < 4 && budget < 20) begin
            set_req(32'd100 + n0, 32'd7, OP_OR);
            cycle(acc);
            if (acc) n0++;
            budget++;
        end
        bus.req_valid = 1'b0;
        chk("rst_fill", n0, 32'd4);
        chk("rst_pre_valid", {31'd0, bus.rsp_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_async_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_async_alu_a", bus.alu_a, 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle(acc);
            chk("rst_no_stale", {31'd0, bus.rsp_valid}, 32'd0);
        end
        push_wait(32'd1, 32'd1, OP_ADD);
        cycle(acc);
        chk("rst_new_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("rst_new_c", bus.rsp_c, 32'd2);
        drain();

        chk("final_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
